mul64_slave: RTL and testbench

- Bus-slave multiplier peripheral at the responder end of the shared 8-bit-address / 32-bit-data register bus.
- The factorial host writes two 64-bit operands, starts the operation, polls status and reads the 128-bit product.
- Implements a fixed-latency sequential radix-2 shift-add 64x64 multiplier.
- Provides status, interrupt-enable and clear registers.

---
 rtl/mul64_slave.sv | 152 +++++++++++++++
 tb/tb_mul64_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul64_slave.sv
// mul64_slave: register-bus slave wrapping a sequential radix-2 shift-add
// 64x64 multiplier with status, interrupt-enable and clear registers.
module mul64_slave #(
    parameter int unsigned N_ITER = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        S_sel,
    input  logic        S_wr,
    input  logic [7:0]  S_address,
    input  logic [31:0] S_din,
    output logic [31:0] S_dout,
    output logic        m_interrupt
);

    localparam logic [7:0] ADDR_A_LO   = 8'h20;
    localparam logic [7:0] ADDR_A_HI   = 8'h21;
    localparam logic [7:0] ADDR_B_LO   = 8'h22;
    localparam logic [7:0] ADDR_B_HI   = 8'h23;
    localparam logic [7:0] ADDR_P0     = 8'h24;
    localparam logic [7:0] ADDR_P1     = 8'h25;
    localparam logic [7:0] ADDR_P2     = 8'h26;
    localparam logic [7:0] ADDR_P3     = 8'h27;
    localparam logic [7:0] ADDR_START  = 8'h28;
    localparam logic [7:0] ADDR_STATUS = 8'h29;
    localparam logic [7:0] ADDR_INTR   = 8'h2A;
    localparam logic [7:0] ADDR_CLEAR  = 8'h2B;

    localparam logic [5:0] LAST_CNT = 6'(N_ITER - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e        state_q;
    logic [63:0]   a_q;
    logic [63:0]   b_q;
    logic [127:0]  p_q;
    logic [127:0]  acc_q;
    logic [127:0]  mcand_q;
    logic [63:0]   mplier_q;
    logic [5:0]    cnt_q;
    logic          done_q;
    logic          intr_en_q;

    logic          wr_en;
    logic          busy;
    logic          start_req;
    logic          clear_req;
    logic [127:0]  acc_next;

    // Decode bus write strobes and the next accumulator value for this step.
    always_comb begin
        wr_en     = S_sel & S_wr;
        busy      = (state_q == StExec);
        start_req = wr_en && (S_address == ADDR_START) && S_din[0];
        clear_req = wr_en && (S_address == ADDR_CLEAR) && S_din[0];
        acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Operand/config registers and the multiplier FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            intr_en_q <= 1'b0;
        end else begin
            // INTR_EN is writable in every state.
            if (wr_en && (S_address == ADDR_INTR)) begin
                intr_en_q <= S_din[0];
            end

            // Operands are frozen while a multiply is running.
            if (wr_en && !busy) begin
                unique case (S_address)
                    ADDR_A_LO: a_q[31:0]  <= S_din;
                    ADDR_A_HI: a_q[63:32] <= S_din;
                    ADDR_B_LO: b_q[31:0]  <= S_din;
                    ADDR_B_HI: b_q[63:32] <= S_din;
                    default: ;
                endcase
            end

            if (clear_req) begin
                // Clear wins in any state, including a running multiply.
                state_q <= StIdle;
                p_q     <= '0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (start_req) begin
                            mcand_q  <= {64'b0, a_q};
                            mplier_q <= b_q;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            done_q   <= 1'b0;
                            state_q  <= StExec;
                        end
                    end
                    StExec: begin
                        acc_q    <= acc_next;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == LAST_CNT) begin
                            p_q     <= acc_next;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Combinational read mux; zero when not selected for a read.
    always_comb begin
        S_dout = '0;
        if (S_sel && !S_wr) begin
            unique case (S_address)
                ADDR_A_LO:   S_dout = a_q[31:0];
                ADDR_A_HI:   S_dout = a_q[63:32];
                ADDR_B_LO:   S_dout = b_q[31:0];
                ADDR_B_HI:   S_dout = b_q[63:32];
                ADDR_P0:     S_dout = p_q[31:0];
                ADDR_P1:     S_dout = p_q[63:32];
                ADDR_P2:     S_dout = p_q[95:64];
                ADDR_P3:     S_dout = p_q[127:96];
                ADDR_STATUS: S_dout = {30'b0, done_q, busy};
                ADDR_INTR:   S_dout = {31'b0, intr_en_q};
                default:     S_dout = '0;
            endcase
        end
    end

    // Level interrupt derived directly from registers.
    always_comb begin
        m_interrupt = done_q & intr_en_q;
    end

endmodule

// File: tb/tb_mul64_slave.sv
// Directed self-checking bench for mul64_slave.
module tb_mul64_slave;

    logic        clk;
    logic        reset;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        m_interrupt;

    int checks;
    int failures;

    mul64_slave dut (
        .clk         (clk),
        .reset       (reset),
        .S_sel       (S_sel),
        .S_wr        (S_wr),
        .S_address   (S_address),
        .S_din       (S_din),
        .S_dout      (S_dout),
        .m_interrupt (m_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus write, committed on the next rising edge.
    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        S_sel = 1'b1;
        S_wr = 1'b1;
        S_address = addr;
        S_din = data;
        @(posedge clk);
        #1;
        S_sel = 1'b0;
        S_wr = 1'b0;
        S_din = '0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        S_sel = 1'b1;
        S_wr = 1'b0;
        S_address = addr;
        #1;
        data = S_dout;
        S_sel = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        chk(tag, d, exp);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b);
        wr(8'h20, a[31:0]);
        wr(8'h21, a[63:32]);
        wr(8'h22, b[31:0]);
        wr(8'h23, b[63:32]);
    endtask

    // Poll STATUS.done with a cycle bound; timeout counts as a failure.
    task automatic wait_done(input string tag);
        logic [31:0] d;
        int n;
        n = 0;
        d = '0;
        while (d[1] !== 1'b1 && n < 200) begin
            rd(8'h29, d);
            n++;
        end
        chk(tag, {31'b0, d[1]}, 32'd1);
    endtask

    task automatic chk_product(input string tag, input logic [127:0] exp);
        rd_chk({tag, "_p0"}, 8'h24, exp[31:0]);
        rd_chk({tag, "_p1"}, 8'h25, exp[63:32]);
        rd_chk({tag, "_p2"}, 8'h26, exp[95:64]);
        rd_chk({tag, "_p3"}, 8'h27, exp[127:96]);
    endtask

    initial begin
        logic [31:0] d;
        int busy_cnt;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        S_sel = 1'b0;
        S_wr = 1'b0;
        S_address = '0;
        S_din = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: every register reads zero.
        for (int a = 8'h20; a <= 8'h2B; a++) begin
            rd_chk("reset_read", 8'(a), 32'd0);
        end
        chk("reset_irq", {31'b0, m_interrupt}, 32'd0);

        // 5 * 3 with cycle-exact latency.
        load(64'd5, 64'd3);
        wr(8'h28, 32'd1);
        S_sel = 1'b1;
        S_wr = 1'b0;
        S_address = 8'h29;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (S_dout === 32'd1) busy_cnt++;
            else break;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd64);
        chk("status_done", S_dout, 32'd2);
        S_sel = 1'b0;
        chk_product("mul5x3", 128'd15);
        rd_chk("readback_a_lo", 8'h20, 32'd5);
        rd_chk("start_reads0", 8'h28, 32'd0);

        // All-ones operands.
        load(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(8'h28, 32'd1);
        wait_done("done_ones");
        chk_product("mul_ones", 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
        chk("irq_disabled", {31'b0, m_interrupt}, 32'd0);

        // Interrupt path with 2^32 * 2^32.
        wr(8'h2A, 32'd1);
        rd_chk("intr_en_read", 8'h2A, 32'd1);
        load(64'h1_0000_0000, 64'h1_0000_0000);
        wr(8'h28, 32'd1);
        @(negedge clk);
        chk("irq_low_busy", {31'b0, m_interrupt}, 32'd0);
        wait_done("done_pow");
        chk("irq_high", {31'b0, m_interrupt}, 32'd1);
        chk_product("mul_pow", 128'h00000000_00000001_00000000_00000000);
        wr(8'h2B, 32'd1);
        chk("irq_after_clear", {31'b0, m_interrupt}, 32'd0);
        rd_chk("status_after_clear", 8'h29, 32'd0);
        chk_product("clear", 128'd0);
        rd_chk("a_kept_clear", 8'h21, 32'd1);
        rd_chk("intr_kept_clear", 8'h2A, 32'd1);

        // Operand and start writes ignored while busy.
        load(64'd7, 64'd6);
        wr(8'h28, 32'd1);
        repeat (8) @(negedge clk);
        wr(8'h20, 32'd9);
        wr(8'h28, 32'd1);
        rd_chk("status_busy", 8'h29, 32'd1);
        wait_done("done_76");
        chk_product("mul7x6", 128'd42);
        rd_chk("a_not_overwritten", 8'h20, 32'd7);
        chk("irq_76", {31'b0, m_interrupt}, 32'd1);
        wr(8'h2A, 32'd0);
        chk("irq_en_off", {31'b0, m_interrupt}, 32'd0);
        wr(8'h2A, 32'd1);

        // Clear mid-operation aborts.
        wr(8'h28, 32'd1);
        repeat (18) @(negedge clk);
        wr(8'h2B, 32'd1);
        rd_chk("status_abort", 8'h29, 32'd0);
        repeat (80) @(negedge clk);
        rd_chk("status_abort_late", 8'h29, 32'd0);
        chk_product("abort", 128'd0);
        chk("irq_abort", {31'b0, m_interrupt}, 32'd0);

        // Start with bit0=0 has no effect.
        wr(8'h28, 32'd2);
        rd_chk("start_bit0_zero", 8'h29, 32'd0);

        // Reset mid-operation.
        wr(8'h28, 32'd1);
        repeat (28) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_irq_mid", {31'b0, m_interrupt}, 32'd0);
        chk("reset_dout_idle", S_dout, 32'd0);
        rd_chk("reset_status_mid", 8'h29, 32'd0);
        rd_chk("reset_intr_en", 8'h2A, 32'd0);
        rd_chk("reset_a", 8'h20, 32'd0);
        chk_product("reset_mid", 128'd0);
        load(64'd2, 64'd2);
        wr(8'h28, 32'd1);
        wait_done("done_2x2");
        chk_product("mul2x2", 128'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
